// File: rtl/leve_axi_pkg.sv
// Shared AXI definitions for the leve responders: burst encodings, response codes, responder FSM states.
// Burst encodings line up with the AXI_BURST_* values in defs.vh.
package leve_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } rsp_state_e;

  // WRAP is only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/leve_axi_addr_gen.sv
// Combinational AXI next-beat address: FIXED holds, INCR steps by 2**size, WRAP steps
// inside the aligned (len+1)*2**size byte window. Shared by read and write responders.
module leve_axi_addr_gen
  import leve_axi_pkg::*;
(
  input  logic [31:0] addr,
  input  axi_burst_e  burst,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] incr;
  logic [31:0] win_mask;

  always_comb begin
    step      = 32'd1 << size;
    incr      = addr + step;
    // Window size is a power of two whenever the caller only issues legal WRAP lengths.
    win_mask  = (({24'd0, len} + 32'd1) << size) - 32'd1;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (addr & ~win_mask) | (incr & win_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/leve_imem_axir_rsp.sv
// AXI4 read responder backed by a word array, with a backdoor write port for program loading.
// Define LEVE_IMEM_DECERR_EN to answer out-of-range beats with DECERR instead of wrapping the index.
module leve_imem_axir_rsp
  import leve_axi_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 4096,
  parameter logic [31:0] BASE   = 32'h0
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  input  logic [31:0]              ARADDR,
  input  logic [1:0]               ARBURST,
  input  logic [7:0]               ARLEN,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] WADDR,
  input  logic [DATA_W-1:0]        WDATA
);

  localparam int          S        = DATA_W / 8;
  localparam int          SHIFT    = $clog2(S);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] LOW_MASK = 32'(S - 1);

  rsp_state_e        state_q, state_d;
  logic [31:0]       cur_addr, gen_addr, load_addr, ar_addr;
  axi_burst_e        burst_q, ar_raw, ar_burst;
  logic [7:0]        len_q, beat_cnt;
  logic              slverr_q, ar_slverr, load_slverr;
  logic              ar_fire, beat_fire, load;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] beat_data;
  logic [1:0]        beat_resp;
  logic [DATA_W-1:0] mem [DEPTH];

  assign ARREADY   = (state_q == ST_IDLE) && RSTn;
  assign ar_fire   = ARVALID && ARREADY;
  assign beat_fire = RVALID && RREADY;
  assign load      = ar_fire || (beat_fire && !RLAST);

  // Illegal bursts still complete, flagged SLVERR, using the nearest legal addressing mode.
  always_comb begin
    ar_raw    = axi_burst_e'(ARBURST);
    ar_addr   = ARADDR & ~LOW_MASK;
    ar_burst  = ar_raw;
    ar_slverr = 1'b0;
    if (ar_raw == BURST_RSVD) begin
      ar_burst  = BURST_FIXED;
      ar_slverr = 1'b1;
    end else if ((ar_raw == BURST_WRAP) && !wrap_len_ok(ARLEN)) begin
      ar_burst  = BURST_INCR;
      ar_slverr = 1'b1;
    end
  end

  leve_axi_addr_gen u_addr_gen (
    .addr      (cur_addr),
    .burst     (burst_q),
    .len       (len_q),
    .size      (3'(SHIFT)),
    .next_addr (gen_addr)
  );

  assign load_addr   = ar_fire ? ar_addr : gen_addr;
  assign load_slverr = ar_fire ? ar_slverr : slverr_q;

`ifdef LEVE_IMEM_DECERR_EN
  logic [32:0] off;
  always_comb begin
    off      = {1'b0, load_addr} - {1'b0, BASE};
    idx      = off[SHIFT +: AW];
    in_range = !off[32] && ((off[31:0] >> SHIFT) < 32'(DEPTH));
  end
`else
  assign idx      = AW'((load_addr - BASE) >> SHIFT);
  assign in_range = 1'b1;
`endif

  always_comb begin
    beat_resp = RESP_OKAY;
    beat_data = mem[idx];
    if (load_slverr) begin
      beat_resp = RESP_SLVERR;
    end else if (!in_range) begin
      beat_resp = RESP_DECERR;
      beat_data = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_fire) state_d = ST_BURST;
      ST_BURST: if (beat_fire && RLAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output stage: beat k+1 is loaded on the handshake of beat k, so RREADY=1 gives one beat per cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RVALID   <= 1'b0;
      RLAST    <= 1'b0;
      RRESP    <= RESP_OKAY;
      RDATA    <= '0;
      beat_cnt <= '0;
    end else begin
      if (ar_fire) begin
        RVALID   <= 1'b1;
        RLAST    <= (ARLEN == 8'd0);
        beat_cnt <= '0;
      end else if (beat_fire) begin
        if (RLAST) begin
          RVALID <= 1'b0;
          RLAST  <= 1'b0;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
          RLAST    <= ((beat_cnt + 8'd1) == len_q);
        end
      end
      if (load) begin
        RDATA <= beat_data;
        RRESP <= beat_resp;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (load) cur_addr <= load_addr;
    if (ar_fire) begin
      burst_q  <= ar_burst;
      len_q    <= ARLEN;
      slverr_q <= ar_slverr;
    end
  end

endmodule

// File: tb/tb_leve_imem_axir_rsp.sv
// Randomized self-checking bench for leve_imem_axir_rsp against a burst-level reference model.
module tb_leve_imem_axir_rsp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
  localparam int S      = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [1:0]  ARBURST;
  logic [7:0]  ARLEN;
  logic        RVALID, RREADY, RLAST;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        WE;
  logic [11:0] WADDR;
  logic [31:0] WDATA;

  int checks = 0;
  int errors = 0;
  logic [31:0] shadow [DEPTH];

  leve_imem_axir_rsp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(32'h0)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit wrap_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic bit is_err_burst(input logic [1:0] burst, input int len);
    return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [1:0] burst,
                                             input int len, input int k);
    logic [31:0] a0, wb, base;
    logic [1:0]  mode;
    a0   = (addr / S) * S;
    mode = burst;
    if (burst == 2'b11) mode = 2'b00;
    else if (burst == 2'b10 && !wrap_ok(len)) mode = 2'b01;
    case (mode)
      2'b01: return a0 + 32'(k * S);
      2'b10: begin
        wb   = 32'((len + 1) * S);
        base = a0 - (a0 % wb);
        return base + ((a0 - base + 32'(k * S)) % wb);
      end
      default: return a0;
    endcase
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [1:0] burst, input int len);
    if (is_err_burst(burst, len)) return 2'b10;
`ifdef LEVE_IMEM_DECERR_EN
    if (a >= 32'(DEPTH * S)) return 2'b11;
`else
    if (a == 32'hFFFF_FFFF) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a, input logic [1:0] resp);
    if (resp == 2'b11) return 32'h0;
    return shadow[(a / S) % DEPTH];
  endfunction

  // mode: 0 = RREADY always high, 1 = 1,0,0 repeating, 2 = random
  task automatic run_burst(input logic [31:0] addr, input logic [1:0] burst, input int len,
                           input int mode, input bit hold_ar);
    int c, beat;
    bit acc;
    logic [31:0] a;
    logic [1:0]  r;
    ARADDR = addr; ARBURST = burst; ARLEN = 8'(len); ARVALID = 1'b1; RREADY = 1'b0;
    c = 0;
    while (!ARREADY && c < 50) begin tick(); c++; end
    if (!ARREADY) begin
      chk("ar_timeout", 64'd0, 64'd1);
      ARVALID = 1'b0;
      return;
    end
    tick();
    ARVALID = hold_ar;
    chk("first_rvalid", 64'(RVALID), 64'd1);
    beat = 0; c = 0;
    while (beat <= len && c < 400) begin
      a = model_addr(addr, burst, len, beat);
      r = model_resp(a, burst, len);
      chk("rvalid", 64'(RVALID), 64'd1);
      chk("arready_busy", 64'(ARREADY), 64'd0);
      chk("rdata", 64'(RDATA), 64'(model_data(a, r)));
      chk("rresp", 64'(RRESP), 64'(r));
      chk("rlast", 64'(RLAST), 64'(beat == len));
      if (mode == 0)      RREADY = 1'b1;
      else if (mode == 1) RREADY = (c % 3 == 0);
      else                RREADY = 1'($urandom_range(0, 1));
      acc = RREADY && RVALID;
      tick();
      c++;
      if (acc) beat++;
    end
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    if (beat <= len) chk("r_timeout", 64'd0, 64'd1);
    chk("rvalid_end", 64'(RVALID), 64'd0);
    chk("arready_end", 64'(ARREADY), 64'd1);
  endtask

  task automatic bd_write(input int i, input logic [31:0] d);
    WE = 1'b1; WADDR = 12'(i); WDATA = d;
    tick();
    WE = 1'b0;
    shadow[i] = d;
  endtask

  initial begin
    int c;
    logic [1:0]  b;
    int          len;
    logic [31:0] addr;
    RSTn = 1'b1; ARVALID = 1'b0; ARADDR = '0; ARBURST = '0; ARLEN = '0;
    RREADY = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
    #1 RSTn = 1'b0;
    #2;
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);

    for (int i = 0; i < DEPTH; i++) bd_write(i, 32'hA000_0000 + 32'(i));
    RSTn = 1'b1;
    tick();
    chk("arready_after_rst", 64'(ARREADY), 64'd1);

    run_burst(32'h08, 2'b10, 3, 0, 1'b0);
    run_burst(32'h08, 2'b10, 3, 1, 1'b0);
    run_burst(32'h10, 2'b01, 7, 0, 1'b1);
    run_burst(32'h20, 2'b10, 2, 0, 1'b0);
    run_burst(32'h34, 2'b11, 1, 1, 1'b0);
    run_burst(32'h0000_4000, 2'b01, 0, 0, 1'b0);

    // Reset in the middle of a 4-beat line fill
    ARADDR = 32'h08; ARBURST = 2'b10; ARLEN = 8'd3; ARVALID = 1'b1;
    c = 0;
    while (!ARREADY && c < 50) begin tick(); c++; end
    tick();
    ARVALID = 1'b0; RREADY = 1'b1;
    tick();
    tick();
    chk("pre_rst_rvalid", 64'(RVALID), 64'd1);
    RSTn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(RVALID), 64'd0);
    chk("midrst_arready", 64'(ARREADY), 64'd0);
    chk("midrst_rlast", 64'(RLAST), 64'd0);
    RREADY = 1'b0;
    tick();
    RSTn = 1'b1;
    #1;
    chk("post_rst_arready", 64'(ARREADY), 64'd1);
    chk("post_rst_rvalid", 64'(RVALID), 64'd0);
    run_burst(32'h08, 2'b10, 3, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) bd_write(int'($urandom_range(0, DEPTH - 1)), $urandom);
      b = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: len = 0;
        1: len = 1;
        2: len = 3;
        3: len = 7;
        4: len = 15;
        default: len = int'($urandom_range(0, 20));
      endcase
      if ($urandom_range(0, 9) == 0) addr = 32'h0000_4000 + 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, DEPTH - 1) * S + $urandom_range(0, 3));
      run_burst(addr, b, len, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
